// File: rtl/id_exe_stage_reg_pkg.sv
// Shared definitions for the ID->EXE pipeline register: ALU command codes
// and the control bundle that travels with every instruction.
package id_exe_stage_reg_pkg;

    localparam int EXE_CMD_W = 4;

    // Controller encodings, consumed unchanged by the EXE stage.
    localparam logic [EXE_CMD_W-1:0] EXE_NOP = 4'b0000;
    localparam logic [EXE_CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [EXE_CMD_W-1:0] EXE_MVN = 4'b1001;
    localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [EXE_CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [EXE_CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [EXE_CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [EXE_CMD_W-1:0] EXE_EOR = 4'b1000;
    localparam logic [EXE_CMD_W-1:0] EXE_TST = 4'b0110;

    typedef struct packed {
        logic [EXE_CMD_W-1:0] exe_cmd;
        logic                 mem_read;
        logic                 mem_write;
        logic                 wb_en;
        logic                 s;
        logic                 b;
    } ctrl_t;

    // A bubble carries no side effects: no memory, register file or flag writes.
    localparam ctrl_t NOP_CTRL = '{
        exe_cmd:   EXE_NOP,
        mem_read:  1'b0,
        mem_write: 1'b0,
        wb_en:     1'b0,
        s:         1'b0,
        b:         1'b0
    };

endpackage

// File: rtl/id_exe_stage_reg_sat_counter.sv
// Saturating up-counter; shared by the pipeline registers to count
// inserted bubbles without ever wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             hold,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && !hold && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register with freeze / flush / hazard-bubble handling
// and a saturating bubble counter for performance readout.
module id_exe_stage_reg
    import id_exe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 freeze,
    input  logic                 flush,
    input  logic                 hazard,
    input  logic [EXE_CMD_W-1:0] exe_cmd_in,
    input  logic                 mem_read_in,
    input  logic                 mem_write_in,
    input  logic                 wb_en_in,
    input  logic                 s_in,
    input  logic                 b_in,
    input  logic [DATA_W-1:0]    pc_in,
    input  logic [DATA_W-1:0]    val_rn_in,
    input  logic [DATA_W-1:0]    val_rm_in,
    input  logic                 imm_in,
    input  logic [11:0]          shift_operand_in,
    input  logic [23:0]          signed_imm24_in,
    input  logic [3:0]           dest_in,
    input  logic [3:0]           src1_in,
    input  logic [3:0]           src2_in,
    input  logic [3:0]           sr_in,
    output logic [EXE_CMD_W-1:0] exe_cmd_out,
    output logic                 mem_read_out,
    output logic                 mem_write_out,
    output logic                 wb_en_out,
    output logic                 s_out,
    output logic                 b_out,
    output logic [DATA_W-1:0]    pc_out,
    output logic [DATA_W-1:0]    val_rn_out,
    output logic [DATA_W-1:0]    val_rm_out,
    output logic                 imm_out,
    output logic [11:0]          shift_operand_out,
    output logic [23:0]          signed_imm24_out,
    output logic [3:0]           dest_out,
    output logic [3:0]           src1_out,
    output logic [3:0]           src2_out,
    output logic [3:0]           sr_out,
    output logic                 valid_out,
    output logic [CNT_W-1:0]     bubble_cnt
);

    ctrl_t w_ctrl_in;
    logic  w_bubble;
    logic  w_hold;

    ctrl_t             r_ctrl;
    logic              r_valid;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_val_rn;
    logic [DATA_W-1:0] r_val_rm;
    logic              r_imm;
    logic [11:0]       r_shift_operand;
    logic [23:0]       r_signed_imm24;
    logic [3:0]        r_dest;
    logic [3:0]        r_src1;
    logic [3:0]        r_src2;
    logic [3:0]        r_sr;

    assign w_ctrl_in = '{
        exe_cmd:   exe_cmd_in,
        mem_read:  mem_read_in,
        mem_write: mem_write_in,
        wb_en:     wb_en_in,
        s:         s_in,
        b:         b_in
    };

    // Flush wins over freeze, freeze wins over hazard; a bubble is at most one per edge.
    assign w_bubble = flush | (hazard & ~freeze);
    assign w_hold   = freeze & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl          <= NOP_CTRL;
            r_valid         <= 1'b0;
            r_pc            <= '0;
            r_val_rn        <= '0;
            r_val_rm        <= '0;
            r_imm           <= 1'b0;
            r_shift_operand <= '0;
            r_signed_imm24  <= '0;
            r_dest          <= '0;
            r_src1          <= '0;
            r_src2          <= '0;
            r_sr            <= '0;
        end else if (!w_hold) begin
            r_ctrl          <= w_bubble ? NOP_CTRL : w_ctrl_in;
            r_valid         <= ~w_bubble;
            // Data fields are don't-care in a bubble, so they load unconditionally.
            r_pc            <= pc_in;
            r_val_rn        <= val_rn_in;
            r_val_rm        <= val_rm_in;
            r_imm           <= imm_in;
            r_shift_operand <= shift_operand_in;
            r_signed_imm24  <= signed_imm24_in;
            r_dest          <= dest_in;
            r_src1          <= src1_in;
            r_src2          <= src2_in;
            r_sr            <= sr_in;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_bubble),
        .hold  (w_hold),
        .count (bubble_cnt)
    );

    assign exe_cmd_out       = r_ctrl.exe_cmd;
    assign mem_read_out      = r_ctrl.mem_read;
    assign mem_write_out     = r_ctrl.mem_write;
    assign wb_en_out         = r_ctrl.wb_en;
    assign s_out             = r_ctrl.s;
    assign b_out             = r_ctrl.b;
    assign valid_out         = r_valid;
    assign pc_out            = r_pc;
    assign val_rn_out        = r_val_rn;
    assign val_rm_out        = r_val_rm;
    assign imm_out           = r_imm;
    assign shift_operand_out = r_shift_operand;
    assign signed_imm24_out  = r_signed_imm24;
    assign dest_out          = r_dest;
    assign src1_out          = r_src1;
    assign src2_out          = r_src2;
    assign sr_out            = r_sr;

endmodule
